// File: rtl/writeback_stage_v2.sv
// Writeback stage: one-entry stage register fed by a valid/ready handshake.
// ALU results retire in one cycle; loads wait for the data bus, then extract and extend.
module writeback_stage_v2 #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_kind,
  input  logic [REG_W-1:0]               in_dst,
  input  logic [DATA_W-1:0]              in_val,
  input  logic [1:0]                     in_lsize,
  input  logic                           in_lsign,
  input  logic [$clog2(DATA_W/8)-1:0]    in_boff,
  input  logic                           dresp_data_ok,
  input  logic [DATA_W-1:0]              dresp_data,
  output logic                           wr_en,
  output logic [REG_W-1:0]               wr_reg,
  output logic [DATA_W-1:0]              wr_data,
  output logic                           fwd_valid,
  output logic [REG_W-1:0]               fwd_reg,
  output logic [DATA_W-1:0]              fwd_data,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic                           resp_err
);

  localparam int BOFF_W = $clog2(DATA_W/8);

  localparam logic [1:0] KIND_ALU  = 2'd1;
  localparam logic [1:0] KIND_LOAD = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state;
  logic                is_alu_q;
  logic [REG_W-1:0]    dst_q;
  logic [DATA_W-1:0]   val_q;
  logic [1:0]          lsize_q;
  logic                lsign_q;
  logic [BOFF_W-1:0]   boff_q;

  logic                accept;
  logic                dst_nz;
  int unsigned         nbits;
  logic [DATA_W-1:0]   sh;
  logic [DATA_W-1:0]   mask;
  logic                sign;
  logic [DATA_W-1:0]   ext;

  assign in_ready = (state != WAIT) || dresp_data_ok;
  assign accept   = in_valid && in_ready;
  assign dst_nz   = (dst_q != '0);

  // Field width selects a low-bit mask; the sign bit is the mask's top bit.
  always_comb begin
    case (lsize_q)
      2'd0:    nbits = 8;
      2'd1:    nbits = 16;
      2'd2:    nbits = 32;
      default: nbits = (DATA_W == 64) ? 64 : 32;
    endcase
    sh   = dresp_data >> {boff_q, 3'b000};
    mask = {DATA_W{1'b1}} >> (DATA_W - nbits);
    sign = lsign_q && |(sh & ~(mask >> 1) & mask);
    ext  = (sh & mask) | (sign ? ~mask : '0);
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = val_q;
    case (state)
      HOLD: wr_en = is_alu_q && dst_nz;
      WAIT: begin
        wr_en   = dresp_data_ok && dst_nz;
        wr_data = ext;
      end
      default: ;
    endcase
  end

  assign wr_reg    = dst_q;
  assign fwd_valid = wr_en;
  assign fwd_reg   = dst_q;
  assign fwd_data  = wr_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      is_alu_q  <= 1'b0;
      dst_q     <= '0;
      val_q     <= '0;
      lsize_q   <= '0;
      lsign_q   <= 1'b0;
      boff_q    <= '0;
      stall_cnt <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (dresp_data_ok && state != WAIT)
        resp_err <= 1'b1;

      if (state == WAIT && !dresp_data_ok && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;

      if (accept) begin
        state    <= (in_kind == KIND_LOAD) ? WAIT : HOLD;
        is_alu_q <= (in_kind == KIND_ALU);
        dst_q    <= in_dst;
        val_q    <= in_val;
        lsize_q  <= in_lsize;
        lsign_q  <= in_lsign;
        boff_q   <= in_boff;
      end else if (state == HOLD || (state == WAIT && dresp_data_ok)) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/writeback_stage_v2.md
Name: writeback_stage_v2

Overview:
- Parametrised successor to the single-cycle writeback stage.
- Holds one retiring instruction in a stage register and accepts it from the memory stage through a valid/ready handshake.
- ALU-class results write back in one cycle. Loads wait for the data-bus response, then extract the byte, half or word with sign/zero extension and write it to the register file.
- Also provides a bypass value, a stall counter and a sticky protocol-error flag.

Parameters:
- DATA_W, 32, datapath width; must be 32 or 64.
- REG_W, 5, register index width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_kind  in  2  0=NONE, 1=ALU, 2=LOAD, 3=reserved (treated as NONE).
- in_dst  in  REG_W  destination register.
- in_val  in  DATA_W  ALU result.
- in_lsize  in  2  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
- in_lsign  in  1  1=sign-extend, 0=zero-extend.
- in_boff  in  log2(DATA_W/8)  byte offset in the bus word.
- dresp_data_ok  in  1  load data valid this cycle.
- dresp_data  in  DATA_W  raw bus word.
- wr_en  out  1  register-file write enable.
- wr_reg  out  REG_W  write index.
- wr_data  out  DATA_W  write data.
- fwd_valid  out  1  stage holds a final value usable for bypass.
- fwd_reg  out  REG_W  bypass index.
- fwd_data  out  DATA_W  bypass value.
- stall_cnt  out  CNT_W  cycles spent waiting on load data.
- resp_err  out  1  sticky: response arrived with no load pending.

Behaviour:
- Reset values: stage empty, in_ready=1, wr_en=0, wr_reg=0, wr_data=0, fwd_valid=0, stall_cnt=0, resp_err=0.
- States:
  - EMPTY.
  - HOLD: ALU or NONE instruction resident.
  - WAIT: load resident, no data yet.
- Accept rule: accept when in_valid && in_ready. The instruction enters the stage register on that clock edge.
- in_ready (combinational):
  - 1 in EMPTY and in HOLD.
  - 1 in WAIT only in a cycle where dresp_data_ok=1, so a back-to-back accept can occur.
- HOLD:
  - ALU: wr_en=1, wr_reg=dst, wr_data=val, all combinational in the resident cycle; fwd_valid=1 with the same reg and data.
  - NONE: wr_en=0 and fwd_valid=0.
  - Next state: EMPTY, or the new instruction if one is accepted.
- WAIT:
  - wr_en=dresp_data_ok.
  - wr_data=extract(dresp_data).
  - fwd_valid=dresp_data_ok, with fwd_data equal to wr_data.
  - Without data: stay in WAIT and increment stall_cnt, saturating at all-ones.
- extract:
  - Field = dresp_data shifted right by boff*8, masked to 8/16/32/64 bits.
  - Extend to DATA_W by the sign bit when lsign=1, with zeros otherwise.
  - lsize=3 with DATA_W=32 behaves as word.
  - The offset is taken as given; misalignment is the producer's responsibility.
- dst==0 (wr_reg, fwd_reg index 0): wr_en and fwd_valid are forced 0 for all kinds; a load still waits for and consumes its response.
- dresp_data_ok outside WAIT: response ignored, resp_err set to 1 until reset.
- No response may be consumed in the accept cycle of a load; latency from accept to write is at least 1 cycle.
- Reset mid-WAIT: the stage empties immediately; a later stray response sets resp_err.
- Writes are combinational from the stage register and the response, so the write-data path has zero added latency.

Test Plan:
- Accept ALU dst=3, val=0x1234 -> next cycle wr_en=1, wr_reg=3, wr_data=0x1234, fwd_valid=1; the cycle after, wr_en=0.
- Load byte signed, boff=2, after 3 cycles data_ok with dresp_data=0x0080FF00 -> wr_data=0xFFFFFF80, stall_cnt=3, wr_en pulses for 1 cycle.
- Load half unsigned, boff=2, data=0x8001_0000 -> wr_data=0x00008001; a back-to-back ALU accepted in the data_ok cycle writes on the next cycle.
- ALU and load with dst=0 -> wr_en never 1; the load still consumes data_ok and returns to EMPTY.
- data_ok while EMPTY -> resp_err=1 and it stays 1 until reset asserts.
- Reset asserted in WAIT -> all outputs return to reset values asynchronously; in_ready=1.
